// File: rtl/dbus_wishbone_if_pkg.sv
// Shared types and constants for the data-side Wishbone bus interface.
// The instruction-side interface will reuse the same definitions.
package dbus_wishbone_if_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam int          StallBusW   = 6;

  typedef enum logic [1:0] {
    DBUS_IDLE           = 2'b00,
    DBUS_BUSY           = 2'b01,
    DBUS_WAIT_FOR_STALL = 2'b10
  } dbus_state_e;

  // Request fields held on the bus for the whole classic cycle.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/dbus_wishbone_if_ack_timer.sv
// Ack watchdog: counts waiting cycles and flags the last permitted one.
// expire is combinational from the count; ACK_TIMEOUT=0 disables it.
module dbus_ack_timer #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (ACK_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/dbus_wishbone_if.sv
// MEM-stage to Wishbone classic bridge: one bus cycle per request, stalls the pipeline until ack.
// Load data is returned in the ack cycle and held in rd_buf while the pipeline is stalled elsewhere.
module dbus_wishbone_if
  import dbus_wishbone_if_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [StallBusW-1:0] stall_i,
  input  logic                 flush_i,
  input  logic                 cpu_ce_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_we_i,
  input  logic [3:0]           cpu_sel_i,
  output logic [31:0]          cpu_data_o,
  output logic                 stallreq_o,
  output logic                 bus_err_o,
  input  logic [31:0]          wishbone_data_i,
  input  logic                 wishbone_ack_i,
  output logic [31:0]          wishbone_addr_o,
  output logic [31:0]          wishbone_data_o,
  output logic                 wishbone_we_o,
  output logic [3:0]           wishbone_sel_o,
  output logic                 wishbone_stb_o,
  output logic                 wishbone_cyc_o
);

  dbus_state_e state, state_nxt;
  wb_req_t     req, req_nxt;
  logic        cyc, cyc_nxt;
  logic [31:0] rd_buf, rd_buf_nxt;
  logic        bus_err, bus_err_nxt;
  logic        timer_clear, timer_run, expire;
  logic        stall_busy;

  assign stall_busy = (stall_i != '0);

  dbus_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_ack_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .run   (timer_run),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state   <= DBUS_IDLE;
      req     <= '0;
      cyc     <= 1'b0;
      rd_buf  <= ZeroWord;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      req     <= req_nxt;
      cyc     <= cyc_nxt;
      rd_buf  <= rd_buf_nxt;
      bus_err <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = req;
    cyc_nxt     = cyc;
    rd_buf_nxt  = rd_buf;
    bus_err_nxt = 1'b0;
    stallreq_o  = 1'b0;
    cpu_data_o  = ZeroWord;
    timer_clear = 1'b1;
    timer_run   = 1'b0;

    case (state)
      DBUS_IDLE: begin
        if ((cpu_ce_i == ChipEnable) && !flush_i) begin
          stallreq_o = 1'b1;
          req_nxt    = '{addr: cpu_addr_i, data: cpu_data_i, we: cpu_we_i, sel: cpu_sel_i};
          cyc_nxt    = 1'b1;
          rd_buf_nxt = ZeroWord;
          state_nxt  = DBUS_BUSY;
        end
      end

      DBUS_BUSY: begin
        timer_clear = 1'b0;
        // Flush beats ack, ack beats timeout when they land in the same cycle.
        if (flush_i) begin
          req_nxt    = '0;
          cyc_nxt    = 1'b0;
          rd_buf_nxt = ZeroWord;
          state_nxt  = DBUS_IDLE;
        end else if (wishbone_ack_i) begin
          req_nxt = '0;
          cyc_nxt = 1'b0;
          if (req.we != WriteEnable) begin
            rd_buf_nxt = wishbone_data_i;
            cpu_data_o = wishbone_data_i;
          end
          state_nxt = stall_busy ? DBUS_WAIT_FOR_STALL : DBUS_IDLE;
        end else if (expire) begin
          req_nxt     = '0;
          cyc_nxt     = 1'b0;
          rd_buf_nxt  = ZeroWord;
          bus_err_nxt = 1'b1;
          state_nxt   = stall_busy ? DBUS_WAIT_FOR_STALL : DBUS_IDLE;
        end else begin
          timer_run  = 1'b1;
          stallreq_o = 1'b1;
        end
      end

      DBUS_WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf;
        if (flush_i) begin
          rd_buf_nxt = ZeroWord;
          state_nxt  = DBUS_IDLE;
        end else if (!stall_busy) begin
          state_nxt = DBUS_IDLE;
        end
      end

      default: state_nxt = DBUS_IDLE;
    endcase
  end

  assign wishbone_addr_o = req.addr;
  assign wishbone_data_o = req.data;
  assign wishbone_we_o   = req.we;
  assign wishbone_sel_o  = req.sel;
  assign wishbone_stb_o  = cyc;
  assign wishbone_cyc_o  = cyc;
  assign bus_err_o       = bus_err;

endmodule

// File: tb/tb_dbus_wishbone_if.sv
// Directed bench for dbus_wishbone_if with a transaction-level reference model.
// Every negedge compares all outputs to the model; literal checks pin key scenarios.
module tb_dbus_wishbone_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  int n_cmp = 0;
  int n_bad = 0;

  dbus_wishbone_if #(.ACK_TIMEOUT(TO), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .cpu_ce_i       (cpu_ce_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_we_i       (cpu_we_i),
    .cpu_sel_i      (cpu_sel_i),
    .cpu_data_o     (cpu_data_o),
    .stallreq_o     (stallreq_o),
    .bus_err_o      (bus_err_o),
    .wishbone_data_i(wishbone_data_i),
    .wishbone_ack_i (wishbone_ack_i),
    .wishbone_addr_o(wishbone_addr_o),
    .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o  (wishbone_we_o),
    .wishbone_sel_o (wishbone_sel_o),
    .wishbone_stb_o (wishbone_stb_o),
    .wishbone_cyc_o (wishbone_cyc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, a "holding load data" flag, and a wait count.
  logic        m_active, m_hold, m_we, m_err;
  logic [31:0] m_addr, m_dat, m_buf;
  logic [3:0]  m_sel;
  int          m_waited;
  logic        m_timeout;
  logic        e_stall;
  logic [31:0] e_cdata;

  always_comb begin
    m_timeout = (TO != 0) && (m_waited + 1 == TO);
    e_stall   = 1'b0;
    e_cdata   = '0;
    if (m_active) begin
      e_stall = !flush_i && !wishbone_ack_i && !m_timeout;
      if (!flush_i && wishbone_ack_i && !m_we) e_cdata = wishbone_data_i;
    end else if (m_hold) begin
      e_cdata = m_buf;
    end else begin
      e_stall = cpu_ce_i && !flush_i;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_hold <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_dat <= '0; m_buf <= '0; m_sel <= '0; m_waited <= 0;
    end else begin
      m_err <= 1'b0;
      if (m_active) begin
        if (flush_i) begin
          m_active <= 1'b0;
        end else if (wishbone_ack_i) begin
          m_active <= 1'b0;
          m_buf    <= m_we ? 32'h0 : wishbone_data_i;
          m_hold   <= (stall_i != 0);
        end else if (m_timeout) begin
          m_active <= 1'b0;
          m_err    <= 1'b1;
          m_buf    <= '0;
          m_hold   <= (stall_i != 0);
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (m_hold) begin
        if (flush_i) begin
          m_hold <= 1'b0;
          m_buf  <= '0;
        end else if (stall_i == 0) begin
          m_hold <= 1'b0;
        end
      end else if (cpu_ce_i && !flush_i) begin
        m_active <= 1'b1;
        m_addr   <= cpu_addr_i;
        m_dat    <= cpu_data_i;
        m_we     <= cpu_we_i;
        m_sel    <= cpu_sel_i;
        m_waited <= 0;
        m_buf    <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc",      {31'b0, wishbone_cyc_o}, {31'b0, m_active});
      chk("stb",      {31'b0, wishbone_stb_o}, {31'b0, m_active});
      chk("addr",     wishbone_addr_o, m_active ? m_addr : 32'h0);
      chk("wdata",    wishbone_data_o, m_active ? m_dat : 32'h0);
      chk("we",       {31'b0, wishbone_we_o}, {31'b0, m_active & m_we});
      chk("sel",      {28'b0, wishbone_sel_o}, {28'b0, (m_active ? m_sel : 4'h0)});
      chk("stallreq", {31'b0, stallreq_o}, {31'b0, e_stall});
      chk("cpu_data", cpu_data_o, e_cdata);
      chk("bus_err",  {31'b0, bus_err_o}, {31'b0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    cpu_ce_i = 1'b1; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = w; cpu_sel_i = s;
  endtask

  int  n_hi, n_cyc, n_err;
  logic adv;

  initial begin
    #2;
    chk("rst_cyc",      {31'b0, wishbone_cyc_o}, 32'h0);
    chk("rst_addr",     wishbone_addr_o, 32'h0);
    chk("rst_bus_err",  {31'b0, bus_err_o}, 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    #10 rst = 1'b0;
    tick();

    // Read, ack on the 4th BUSY cycle (coincides with the last pre-timeout cycle).
    request(32'h0000_1004, 32'h0, 1'b0, 4'b1111);
    n_hi = 0;
    for (int i = 0; i < 4; i++) begin
      #3 n_hi += int'(stallreq_o);
      tick();
    end
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEAD_BEEF;
    #3;
    chk("t1_cpu_data", cpu_data_o, 32'hDEAD_BEEF);
    chk("t1_stall_fall", {31'b0, stallreq_o}, 32'h0);
    chk("t1_stall_cycles", n_hi, 32'd4);
    tick();
    cpu_ce_i = 1'b0; wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #3 chk("t1_cyc_low", {31'b0, wishbone_cyc_o}, 32'h0);
    tick();

    // Write, zero-wait ack.
    request(32'h0000_2000, 32'h1234_5678, 1'b1, 4'b0011);
    #3 chk("t2_we_before", {31'b0, wishbone_we_o}, 32'h0);
    tick();
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h7777_7777;
    #3;
    chk("t2_we",       {31'b0, wishbone_we_o}, 32'h1);
    chk("t2_sel",      {28'b0, wishbone_sel_o}, 32'h3);
    chk("t2_wdata",    wishbone_data_o, 32'h1234_5678);
    chk("t2_stall",    {31'b0, stallreq_o}, 32'h0);
    chk("t2_cpu_data", cpu_data_o, 32'h0);
    tick();
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; wishbone_ack_i = 1'b0;
    #3 chk("t2_we_after", {31'b0, wishbone_we_o}, 32'h0);
    tick();

    // Read with external stall: data held in WAIT_FOR_STALL, stray ack ignored.
    request(32'h0000_3000, 32'h0, 1'b0, 4'b1111);
    tick();
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'hCAFE_0001; stall_i = 6'b000011;
    #3 chk("t3_ack_data", cpu_data_o, 32'hCAFE_0001);
    tick();
    cpu_ce_i = 1'b0; wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'hFFFF_FFFF;
      end
      #3;
      chk("t3_hold_data", cpu_data_o, 32'hCAFE_0001);
      chk("t3_hold_stall", {31'b0, stallreq_o}, 32'h0);
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    end
    stall_i = '0;
    #3 chk("t3_last_hold", cpu_data_o, 32'hCAFE_0001);
    tick();
    #3 chk("t3_idle_data", cpu_data_o, 32'h0);
    tick();

    // Flush on the 2nd BUSY cycle, late ack afterwards.
    request(32'h0000_4000, 32'h0, 1'b0, 4'b1111);
    tick();
    tick();
    flush_i = 1'b1;
    #3 chk("t4_flush_stall", {31'b0, stallreq_o}, 32'h0);
    tick();
    flush_i = 1'b0; cpu_ce_i = 1'b0;
    #3 chk("t4_cyc_dropped", {31'b0, wishbone_cyc_o}, 32'h0);
    tick();
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h5555_5555;
    #3 chk("t4_late_ack", cpu_data_o, 32'h0);
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    #3 chk("t4_no_err", {31'b0, bus_err_o}, 32'h0);
    tick();

    // Timeout: no ack ever arrives.
    request(32'h0000_5000, 32'hA5A5_A5A5, 1'b1, 4'b1000);
    n_cyc = 0; n_err = 0;
    for (int i = 0; i < 7; i++) begin
      #3;
      n_cyc += int'(wishbone_cyc_o);
      n_err += int'(bus_err_o);
      adv = !stallreq_o;
      tick();
      if (adv) begin
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
      end
    end
    chk("t5_cyc_cycles", n_cyc, 32'd4);
    chk("t5_err_pulses", n_err, 32'd1);

    // Asynchronous reset in the middle of BUSY.
    request(32'h0000_6000, 32'h0, 1'b0, 4'b1111);
    tick();
    tick();
    #2 rst = 1'b1; cpu_ce_i = 1'b0;
    #1;
    chk("t6_cyc_async", {31'b0, wishbone_cyc_o}, 32'h0);
    chk("t6_stb_async", {31'b0, wishbone_stb_o}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
    #3 chk("t6_idle_stall", {31'b0, stallreq_o}, 32'h0);
    tick();

    // Normal read after reset.
    request(32'h0000_7000, 32'h0, 1'b0, 4'b0001);
    tick();
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0BAD_F00D;
    #3 chk("t7_cpu_data", cpu_data_o, 32'h0BAD_F00D);
    tick();
    cpu_ce_i = 1'b0; wishbone_ack_i = 1'b0; wishbone_data_i = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_wishbone_if.md
Name: dbus_wishbone_if

Overview:
- Data-side bus interface between the MEM stage and the external Wishbone data bus.
- Takes the MEM stage's RAM request signals, runs one single Wishbone classic cycle per request and holds the pipeline with a stall request until ack.
- Returns load data to the MEM stage and buffers that data while the pipeline is stalled for other reasons.
- Includes an ack-timeout watchdog that terminates hung cycles and flags a bus error.

Parameters:
- ACK_TIMEOUT, 255: cycles in BUSY without ack before abort; 0 disables the watchdog.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  6  pipeline stall vector from ctrl
- flush_i  in  1  pipeline flush (exception)
- cpu_ce_i  in  1  request valid (MEM mem_ce_o)
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_we_i  in  1  1=write, 0=read
- cpu_sel_i  in  4  byte lanes, bit3 = bits[31:24]
- cpu_data_o  out  32  load data to MEM stage (combinational)
- stallreq_o  out  1  stall request to ctrl (combinational)
- bus_err_o  out  1  one-cycle pulse on timeout abort (registered)
- wishbone_data_i  in  32  bus read data
- wishbone_ack_i  in  1  bus acknowledge
- wishbone_addr_o  out  32  bus address (registered)
- wishbone_data_o  out  32  bus write data (registered)
- wishbone_we_o  out  1  bus write enable (registered)
- wishbone_sel_o  out  4  bus byte select (registered)
- wishbone_stb_o  out  1  bus strobe (registered)
- wishbone_cyc_o  out  1  bus cycle (registered)

Behaviour:
- Reset (async, rst=1): state=IDLE; all wishbone_* outputs, rd_buf, counter and bus_err_o = 0.
- Reset mid-cycle drops cyc/stb immediately with no completion.
- States: IDLE, BUSY, WAIT_FOR_STALL (2-bit encoding in the package).
- bus_err_o defaults to 0 every cycle; it is high only in the cycle after an abort.

IDLE:
- If cpu_ce_i=1 and flush_i=0:
  - Next edge: cyc=stb=1; addr/data/we/sel latched from cpu_*; counter=0; rd_buf=0; go BUSY.
  - Combinational this cycle: stallreq_o=1, cpu_data_o=0.
- Otherwise: stallreq_o=0, cpu_data_o=0.

BUSY:
- If flush_i=1 (highest priority): next edge cyc=stb=we=0, addr=data=sel=0, rd_buf=0, go IDLE. Combinational: stallreq_o=0, cpu_data_o=0.
- Else if wishbone_ack_i=1:
  - Next edge: cyc=stb=we=0, addr=data=sel=0.
  - If read, rd_buf=wishbone_data_i.
  - Go WAIT_FOR_STALL if stall_i≠0, else IDLE.
  - Combinational: stallreq_o=0; cpu_data_o = read ? wishbone_data_i : 0.
- Else if ACK_TIMEOUT≠0 and counter==ACK_TIMEOUT-1:
  - Abort: cyc/stb and all bus outputs cleared; rd_buf=0; bus_err_o=1 next cycle.
  - Go WAIT_FOR_STALL if stall_i≠0, else IDLE.
  - Combinational: stallreq_o=0, cpu_data_o=0.
- Else: counter+1 (saturating), stallreq_o=1, cpu_data_o=0.

WAIT_FOR_STALL:
- Combinational: stallreq_o=0, cpu_data_o=rd_buf.
- Go IDLE when stall_i==0.
- flush_i=1 forces IDLE and clears rd_buf.

General rules:
- Minimum latency is one request per 2 edges: request cycle, then the ack cycle earliest.
- No pipelined Wishbone: stb stays high until ack/abort/flush.
- ack while in IDLE or WAIT_FOR_STALL is ignored.
- Bus outputs are stable throughout BUSY; cpu_* changes during BUSY are ignored.
- The same request is never reissued: IDLE→BUSY requires passing through the ack/abort release edge, which advances the pipeline.

Decomposition:
- Shared package/defines:
  - state encodings DBUS_IDLE, DBUS_BUSY, DBUS_WAIT_FOR_STALL
  - existing ZeroWord, RstEnable, ChipEnable, WriteEnable
  - StallBus width 6
- Sub-module: one natural candidate, dbus_ack_timer (counter + compare, outputs expire pulse), reused later for the instruction-side interface.

Test Plan:
- Read, ack after 3 BUSY cycles, stall_i=0: addr=0x0000_1004, sel=4'b1111, ack with data=0xDEAD_BEEF → stallreq_o high 4 cycles, cpu_data_o=0xDEADBEEF in ack cycle, cyc/stb low next edge, state IDLE.
- Write, zero-wait: addr=0x0000_2000, data=0x1234_5678, sel=4'b0011, ack in first BUSY cycle → wishbone_we_o=1, sel=0011, data=0x12345678 for exactly 1 cycle; stallreq_o falls in ack cycle; cpu_data_o=0.
- Read with external stall: ack with 0xCAFE_0001 while stall_i=6'b000011 held 3 more cycles → WAIT_FOR_STALL, cpu_data_o=0xCAFE0001 and stallreq_o=0 each cycle; IDLE when stall_i=0.
- Flush during BUSY: flush_i=1 on 2nd BUSY cycle, ack arrives later → cyc/stb drop next edge, late ack ignored, rd_buf=0, no bus_err_o.
- Timeout with ACK_TIMEOUT=4, no ack → cyc high exactly 4 BUSY cycles; bus_err_o 1-cycle pulse; stallreq_o released; cpu_data_o=0.
- Async reset asserted mid-BUSY between clock edges → wishbone_cyc_o/stb_o go 0 immediately without a clock edge; after release, state IDLE.
